// File: rtl/spi_reg_file.sv
// rtl/spi_reg_file.sv - SPI mode-0 write-only target holding the PWM stage control registers.
// All SPI pins are synchronized into clk; frames commit only when chip select rises.

module spi_reg_file #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_copi,
    input  logic       spi_ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_pulse,
    output logic       frame_err
);

    localparam int NUM_PORTS = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic                   r_sclk_d;
    logic                   r_ncs_d;

    logic [15:0] r_shift;
    logic [4:0]  r_cnt;
    logic [7:0]  r_regs [NUM_PORTS];
    logic        r_wr_pulse;
    logic        r_frame_err;

    logic       w_sclk;
    logic       w_copi;
    logic       w_ncs;
    logic       w_sclk_rise;
    logic       w_ncs_fall;
    logic       w_ncs_rise;
    logic       w_clear;
    logic       w_sample;
    logic       w_commit;
    logic [6:0] w_addr;
    logic       w_frame_ok;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_copi      = r_copi_sync[SYNC_STAGES-1];
    assign w_ncs       = r_ncs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_ncs_fall  = ~w_ncs & r_ncs_d;
    assign w_ncs_rise  = w_ncs & ~r_ncs_d;

    // Synchronizers reset low so a chip select already low at reset release is never seen as a fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '0;
            r_sclk_d    <= 1'b0;
            r_ncs_d     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], spi_copi};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], spi_ncs};
            r_sclk_d    <= w_sclk;
            r_ncs_d     <= w_ncs;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_sample     = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ncs_fall) begin
                    w_clear      = 1'b1;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_ncs_rise) begin
                    w_next_state = COMMIT;
                end else if (w_sclk_rise && !w_ncs) begin
                    w_sample = 1'b1;
                end
            end
            COMMIT: begin
                w_commit     = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_addr     = r_shift[14:8];
    assign w_frame_ok = (r_cnt == 5'd16) && r_shift[15] && (32'(w_addr) < NUM_REGS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_sample) begin
            r_shift <= {r_shift[14:0], w_copi};
            if (r_cnt != 5'd17) begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    // Registers only move in COMMIT so downstream never sees a partially shifted value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_regs[i] <= 8'h00;
            end
            r_wr_pulse  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_pulse  <= w_commit && w_frame_ok;
            r_frame_err <= w_commit && !w_frame_ok;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_commit && w_frame_ok && (w_addr == 7'(i))) begin
                    r_regs[i] <= r_shift[7:0];
                end
            end
        end
    end

    assign en_reg_out_7_0  = r_regs[0];
    assign en_reg_out_15_8 = r_regs[1];
    assign en_reg_pwm_7_0  = r_regs[2];
    assign en_reg_pwm_15_8 = r_regs[3];
    assign pwm_duty_cycle  = r_regs[4];
    assign wr_pulse        = r_wr_pulse;
    assign frame_err       = r_frame_err;

endmodule

// File: tb/tb_spi_reg_file.sv
// tb/tb_spi_reg_file.sv - scoreboard bench for spi_reg_file with directed and random SPI frames.
// Stimulus pushes the expected commit outcome; the monitor pops it on each DUT pulse.

module tb_spi_reg_file;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sclk;
    logic       spi_copi;
    logic       spi_ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_pulse;
    logic       frame_err;

    spi_reg_file #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .spi_sclk        (spi_sclk),
        .spi_copi        (spi_copi),
        .spi_ncs         (spi_ncs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_pulse        (wr_pulse),
        .frame_err       (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       is_wr;
        bit [6:0] addr;
        bit [7:0] data;
        int       rise_cyc;
    } exp_t;

    exp_t     exp_q[$];
    bit [7:0] model[5];
    int       cyc = 0;
    int       n_checks = 0;
    int       n_errors = 0;
    int       n_wr_seen = 0;
    int       n_err_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [39:0] outs();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    function automatic logic [39:0] model_outs();
        return {model[4], model[3], model[2], model[1], model[0]};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) model[i] = 8'h00;
            check("reset_outputs", {22'd0, wr_pulse, frame_err, outs()}, 64'd0);
        end else if (wr_pulse || frame_err) begin
            if (wr_pulse) n_wr_seen++;
            if (frame_err) n_err_seen++;
            check("pulse_exclusive", {63'd0, wr_pulse & frame_err}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {62'd0, wr_pulse, frame_err}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind", {62'd0, wr_pulse, frame_err}, e.is_wr ? 64'd2 : 64'd1);
                check("latency_ok", {63'd0, (cyc - e.rise_cyc) >= 3 && (cyc - e.rise_cyc) <= 5}, 64'd1);
                if (e.is_wr) model[e.addr] = e.data;
            end
            check("regs_after_commit", {24'd0, outs()}, {24'd0, model_outs()});
        end else begin
            check("regs_stable", {24'd0, outs()}, {24'd0, model_outs()});
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic begin_frame();
        spi_ncs = 1'b0;
        wait_clk(4);
    endtask

    task automatic clock_bit(input bit b, input int half);
        spi_copi = b;
        wait_clk(half);
        spi_sclk = 1'b1;
        wait_clk(half);
        spi_sclk = 1'b0;
    endtask

    task automatic end_frame(input bit push, input exp_t e, input int gap);
        exp_t ee;
        wait_clk(3);
        spi_ncs = 1'b1;
        ee = e;
        ee.rise_cyc = cyc;
        if (push) exp_q.push_back(ee);
        wait_clk(gap);
    endtask

    task automatic send_frame(input int nbits, input bit rw, input bit [6:0] addr,
                              input bit [7:0] data, input int half, input int gap);
        bit [15:0] f;
        exp_t e;
        f = {rw, addr, data};
        begin_frame();
        for (int i = 0; i < nbits; i++) clock_bit(i < 16 ? f[15 - i] : 1'b1, half);
        e.is_wr = (nbits == 16) && rw && (addr < 7'd5);
        e.addr = addr;
        e.data = data;
        e.rise_cyc = 0;
        end_frame(1'b1, e, gap);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        wait_clk(3);
    endtask

    initial begin
        int wr0;
        int er0;
        exp_t dummy;
        dummy.is_wr = 1'b0;
        dummy.addr = '0;
        dummy.data = '0;
        dummy.rise_cyc = 0;
        rst = 1'b1;
        spi_sclk = 1'b0;
        spi_copi = 1'b0;
        spi_ncs = 1'b1;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(10);
        check("reset_state", {22'd0, wr_pulse, frame_err, outs()}, 64'd0);

        // reset mid-frame: frame is lost, the still-low ncs after release is not a new frame
        wr0 = n_wr_seen; er0 = n_err_seen;
        begin_frame();
        for (int i = 0; i < 8; i++) clock_bit(i == 0, 3);
        rst = 1'b1;
        wait_clk(5);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) clock_bit(1'b1, 3);
        end_frame(1'b0, dummy, 6);
        drain();
        check("reset_no_pulses", n_wr_seen - wr0 + n_err_seen - er0, 0);
        send_frame(16, 1'b1, 7'h00, 8'hFF, 3, 6);
        drain();
        check("reset_then_write", {24'd0, outs()}, 64'h00_00_00_00_FF);

        // full map
        wr0 = n_wr_seen; er0 = n_err_seen;
        send_frame(16, 1'b1, 7'h01, 8'hA5, 3, 4);
        send_frame(16, 1'b1, 7'h02, 8'h3C, 3, 4);
        send_frame(16, 1'b1, 7'h03, 8'h81, 3, 4);
        send_frame(16, 1'b1, 7'h04, 8'h80, 3, 4);
        drain();
        check("full_map_values", {24'd0, outs()}, 64'h80_81_3C_A5_FF);
        check("full_map_wr_count", n_wr_seen - wr0, 4);
        check("full_map_no_err", n_err_seen - er0, 0);

        // rejected frames
        send_frame(16, 1'b1, 7'h04, 8'h55, 3, 4);
        drain();
        wr0 = n_wr_seen; er0 = n_err_seen;
        send_frame(16, 1'b0, 7'h04, 8'hEE, 3, 4);
        send_frame(16, 1'b1, 7'h05, 8'hEE, 3, 4);
        send_frame(16, 1'b1, 7'h7F, 8'hEE, 3, 4);
        drain();
        check("rejected_duty_kept", pwm_duty_cycle, 8'h55);
        check("rejected_err_count", n_err_seen - er0, 3);
        check("rejected_no_write", n_wr_seen - wr0, 0);

        // bad framing
        wr0 = n_wr_seen; er0 = n_err_seen;
        send_frame(15, 1'b1, 7'h00, 8'h12, 3, 4);
        send_frame(17, 1'b1, 7'h00, 8'h12, 3, 4);
        drain();
        check("bad_frame_reg_kept", en_reg_out_7_0, 8'hFF);
        check("bad_frame_err_count", n_err_seen - er0, 2);
        send_frame(16, 1'b1, 7'h00, 8'h12, 3, 4);
        drain();
        check("good_after_bad", en_reg_out_7_0, 8'h12);
        check("bad_frame_wr_count", n_wr_seen - wr0, 1);

        // back-to-back at minimum timing
        wr0 = n_wr_seen;
        for (int v = 0; v < 10; v++) send_frame(16, 1'b1, 7'h04, 8'(v), 3, 4);
        drain();
        check("b2b_wr_count", n_wr_seen - wr0, 10);
        check("b2b_final_value", pwm_duty_cycle, 8'h09);

        // sclk noise while deselected
        wr0 = n_wr_seen; er0 = n_err_seen;
        for (int i = 0; i < 20; i++) begin
            spi_sclk = ~spi_sclk;
            spi_copi = i[0];
            wait_clk(3);
        end
        spi_sclk = 1'b0;
        wait_clk(6);
        check("noise_no_pulses", n_wr_seen - wr0 + n_err_seen - er0, 0);
        send_frame(16, 1'b1, 7'h02, 8'hF0, 3, 4);
        drain();
        check("noise_then_write", en_reg_pwm_7_0, 8'hF0);

        // random frames against the rule-based expectation
        for (int k = 0; k < 30; k++) begin
            int       nb;
            int       sel;
            bit       rw;
            bit [6:0] a;
            sel = $urandom_range(0, 9);
            nb = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
            rw = ($urandom_range(0, 7) != 0);
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
            send_frame(nb, rw, a, 8'($urandom_range(0, 255)), $urandom_range(3, 5), $urandom_range(4, 8));
        end
        drain();
        check("final_regs", {24'd0, outs()}, {24'd0, model_outs()});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
